bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (shift-add-3, one bit per clock). It sits directly downstream of the 10-bit free-running counter stage and consumes its q output.
- On a start request it captures the counter value and converts it to packed decimal digits for the display stage.
- It uses a start/busy/done handshake so the consumer knows when the digits are valid.

---
 rtl/bin2bcd_seq.sv | 126 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Optional leading-zero blanking of the result is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]          state_reg;
    logic [WIDTH-1:0]    shift_reg;
    logic [4*DIGITS-1:0] scratch_reg;
    logic [CW-1:0]       count_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [4*DIGITS-1:0] bcd_reg;

    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] scratch_next;
    logic [WIDTH-1:0]    shift_next;
    logic [4*DIGITS-1:0] result_next;
    logic [DIGITS-1:0]   digit_nz;
    logic [DIGITS-1:0]   upper_nz;
    logic                unused_carry;

    genvar gi;

    // Add-3 correction per digit; no carry propagates between digits.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                                    scratch_reg[gi*4 +: 4] + 4'd3 :
                                    scratch_reg[gi*4 +: 4];
        end
    endgenerate

    assign scratch_next = {adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
    assign shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
    // Top bit of the corrected scratch always shifts out as zero for a legal DIGITS.
    assign unused_carry = adj[4*DIGITS-1];

    // upper_nz[i]: some digit at position i or above is nonzero.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nz
            assign digit_nz[gi] = |scratch_next[gi*4 +: 4];
            if (gi == DIGITS - 1) begin : g_top
                assign upper_nz[gi] = digit_nz[gi];
            end else begin : g_mid
                assign upper_nz[gi] = digit_nz[gi] | upper_nz[gi+1];
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_res
`ifdef BIN2BCD_BLANK_EN
            if (gi == 0) begin : g_units
                assign result_next[gi*4 +: 4] = scratch_next[gi*4 +: 4];
            end else begin : g_upper
                assign result_next[gi*4 +: 4] = upper_nz[gi] ?
                                                scratch_next[gi*4 +: 4] : 4'hF;
            end
`else
            assign result_next[gi*4 +: 4] = scratch_next[gi*4 +: 4];
`endif
        end
    endgenerate

`ifndef BIN2BCD_BLANK_EN
    logic unused_nz;
    assign unused_nz = |upper_nz;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            scratch_reg <= '0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            bcd_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= bin_in;
                        scratch_reg <= '0;
                        count_reg   <= CW'(WIDTH);
                        busy_reg    <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg   <= shift_next;
                    scratch_reg <= scratch_next;
                    count_reg   <= count_reg - 1'b1;
                    if (count_reg == CW'(1)) begin
                        bcd_reg   <= result_next;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized and directed bench for bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 10;
    localparam int DIGITS = 4;

    logic                clk;
    logic                reset;
    logic [WIDTH-1:0]    bin_in;
    logic                start;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;

    int n_cmp;
    int n_err;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .reset  (reset),
        .bin_in (bin_in),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Digit i is (v / 10^i) mod 10; with blanking, digits i>0 where v < 10^i read F.
    function automatic logic [4*DIGITS-1:0] bcd_ref(input int v);
        logic [4*DIGITS-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
`ifdef BIN2BCD_BLANK_EN
            if (i > 0 && v < p) r[i*4 +: 4] = 4'hF;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_conv(input int v);
        int lat;
        int busy_cnt;
        bin_in = WIDTH'(v);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("busy_after_start", busy, 1);
        bin_in = WIDTH'($urandom);
        lat = 0;
        busy_cnt = 1;
        for (int k = 1; k <= 2*WIDTH; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        check("latency", lat, WIDTH);
        check("busy_cycles", busy_cnt, WIDTH);
        check("bcd_value", bcd, bcd_ref(v));
        check("busy_at_done", busy, 0);
        tick();
        check("done_width", done, 0);
        check("bcd_hold", bcd, bcd_ref(v));
        $display("conv in=%0d bcd=%h exp=%h latency=%0d", v, bcd, bcd_ref(v), lat);
    endtask

    initial begin
        int dn_cnt;
        int last_t;
        int cyc;
        int v;
        n_cmp = 0;
        n_err = 0;
        reset  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 0);
        reset = 1'b1;
        tick();
        check("idle_done", done, 0);
        check("idle_bcd", bcd, 0);

        run_conv(1000);
        run_conv(0);
        run_conv(1023);
        run_conv(999);
        run_conv(7);
        run_conv(40);
        for (int i = 0; i < 25; i++) begin
            v = int'($urandom_range(0, 1023));
            run_conv(v);
        end

        // Continuous start: accepts on each done cycle, period WIDTH+1.
        bin_in = WIDTH'(42);
        start  = 1'b1;
        dn_cnt = 0;
        last_t = -1;
        for (cyc = 0; cyc < 100 && dn_cnt < 5; cyc++) begin
            tick();
            if (done) begin
                check("hs_bcd", bcd, bcd_ref(42));
                if (last_t >= 0) check("hs_period", cyc - last_t, WIDTH + 1);
                $display("handshake done #%0d at cycle %0d bcd=%h", dn_cnt, cyc, bcd);
                last_t = cyc;
                dn_cnt++;
            end
        end
        start = 1'b0;
        check("hs_count", dn_cnt, 5);
        tick();
        check("hs_idle_busy", busy, 0);

        // Abort mid-conversion with an asynchronous reset between edges.
        bin_in = WIDTH'(777);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (5) tick();
        check("mid_busy", busy, 1);
        #3;
        reset = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_bcd", bcd, 0);
        $display("async reset at t=%0t busy=%0b bcd=%h", $time, busy, bcd);
        repeat (2) tick();
        reset = 1'b1;
        dn_cnt = 0;
        for (int k = 0; k < 2*WIDTH; k++) begin
            tick();
            if (done) dn_cnt++;
        end
        check("abort_no_done", dn_cnt, 0);
        check("abort_bcd", bcd, 0);
        run_conv(777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
